// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and types for the NeuralNetwork input assembler
package nn_pkg;

    localparam int NN_NUM_INPUTS = 784;
    localparam int NN_DATA_WIDTH = 16;
    localparam int NN_PIX_WIDTH  = 8;
    localparam int NN_PIX_SHIFT  = 5;

    typedef logic signed [15:0] lane_t;

    typedef enum logic {
        FILL,
        PRESENT
    } asm_state_t;

endpackage

// File: rtl/nn_pix2fix.sv
// rtl/nn_pix2fix.sv - unsigned pixel to signed fixed-point lane, shift and saturate
module nn_pix2fix #(
    parameter int PIX_WIDTH  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int PIX_SHIFT  = 5
) (
    input  logic [PIX_WIDTH-1:0]  pix,
    output logic [DATA_WIDTH-1:0] lane
);

    localparam int WIDE = PIX_WIDTH + PIX_SHIFT + DATA_WIDTH;

    logic [WIDE-1:0] wide;
    logic            sat;

    // Anything reaching the sign bit or above overflows the positive range.
    assign wide = WIDE'(pix) << PIX_SHIFT;
    assign sat  = |wide[WIDE-1:DATA_WIDTH-1];
    assign lane = sat ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : wide[DATA_WIDTH-1:0];

endmodule

// File: rtl/nn_input_assembler.sv
// rtl/nn_input_assembler.sv - packs a pixel stream into the NeuralNetwork NNin frame
module nn_input_assembler
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = NN_NUM_INPUTS,
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int PIX_WIDTH  = NN_PIX_WIDTH,
    parameter int PIX_SHIFT  = NN_PIX_SHIFT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PIX_WIDTH-1:0]             pix_data,
    input  logic                             pix_valid,
    input  logic                             pix_sof,
    output logic                             pix_ready,
    input  logic                             nn_done,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] NNin,
    output logic                             NNvalid,
    output logic                             busy,
    output logic                             frame_err
);

    localparam int CW = $clog2(NUM_INPUTS + 1);

    asm_state_t              state, state_nxt;
    logic [CW-1:0]           count, count_nxt, wr_idx;
    logic [DATA_WIDTH-1:0]   lane;
    logic                    accept, sof_err;

    nn_pix2fix #(
        .PIX_WIDTH  (PIX_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PIX_SHIFT  (PIX_SHIFT)
    ) u_pix2fix (
        .pix  (pix_data),
        .lane (lane)
    );

    assign accept = pix_valid & (state == FILL);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_idx    = count;
        sof_err   = 1'b0;
        pix_ready = 1'b0;
        NNvalid   = 1'b0;
        busy      = 1'b0;
        case (state)
            FILL: begin
                pix_ready = 1'b1;
                busy      = (count != '0);
                if (pix_sof) begin
                    wr_idx = '0;
                end
                if (pix_valid) begin
                    // sof restarts the frame at lane 0; a nonzero count means the old frame was short
                    if (pix_sof) begin
                        count_nxt = CW'(1);
                        sof_err   = (count != '0);
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                    if (count_nxt == CW'(NUM_INPUTS)) begin
                        count_nxt = '0;
                        state_nxt = PRESENT;
                    end
                end
            end
            PRESENT: begin
                NNvalid = 1'b1;
                busy    = 1'b1;
                if (nn_done) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FILL;
            count     <= '0;
            NNin      <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            frame_err <= sof_err;
            if (accept) begin
                NNin[int'(wr_idx) * DATA_WIDTH +: DATA_WIDTH] <= lane;
            end
        end
    end

endmodule

// File: doc/nn_input_assembler.md
Name: nn_input_assembler

Overview:
- Upstream feeder for NeuralNetwork: accepts a raster stream of 8-bit grayscale pixels over a valid/ready handshake.
- Converts each pixel to signed fixed point and packs 784 of them into the flat NNin vector.
- Presents NNin with NNvalid, holds it until the network reports completion, then rearms for the next frame.
- Supports single-buffered frames, start-of-frame resync and short-frame error reporting.

Parameters:
- NUM_INPUTS, 784, pixels per frame / input lanes of NeuralNetwork
- DATA_WIDTH, 16, width of each packed lane (Q8.8 signed)
- PIX_WIDTH, 8, incoming pixel width (unsigned)
- PIX_SHIFT, 5, left shift applied to a pixel to form its lane value (255 -> 0x1FE0)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- pix_data  in  PIX_WIDTH  unsigned pixel
- pix_valid  in  1  pix_data/pix_sof valid
- pix_sof  in  1  marks first pixel of a frame
- pix_ready  out  1  block can accept a pixel this cycle
- nn_done  in  1  NeuralNetwork finished with current NNin (tie to NNoutValid)
- NNin  out  NUM_INPUTS*DATA_WIDTH  packed frame; pixel k in bits [k*DATA_WIDTH +: DATA_WIDTH]
- NNvalid  out  1  NNin holds a complete frame
- busy  out  1  frame partially filled or being presented
- frame_err  out  1  one-cycle pulse on short frame

Behaviour:
- Reset (reset==0 at clk edge): state FILL, count=0, NNin=0, NNvalid=0, pix_ready=1, busy=0, frame_err=0. Reset has priority over all other events, including mid-fill and mid-present.
- Accept = pix_valid & pix_ready.
- Conversion: lane = zero-extend(pix_data) << PIX_SHIFT.
  - If the result needs more than DATA_WIDTH-1 magnitude bits, saturate to 0x7FFF (sign bit is never set).
  - Never written to an unaccepted lane.
- States:
  - FILL: pix_ready=1, NNvalid=0.
    - On accept, the lane is written at index count (or 0, see sof rule) and count increments.
    - busy=1 whenever count!=0.
    - On accepting the pixel that makes count reach NUM_INPUTS: count->0, next state PRESENT.
  - PRESENT: NNvalid=1 (registered, high the cycle after the last accept), pix_ready=0, busy=1, NNin frozen.
    - nn_done sampled high -> next cycle NNvalid=0, pix_ready=1, state FILL.
    - nn_done is ignored in FILL.
- SOF rule (FILL only):
  - An accepted pixel with pix_sof=1 is written to lane 0 and count becomes 1.
  - If count was nonzero at that moment, frame_err pulses high for exactly one cycle (the next cycle). Lanes 1..old count-1 keep stale data and are overwritten as the frame refills.
  - pix_sof=1 with count==0 is normal; no error.
- pix_sof=0 on the first pixel of a frame is accepted as lane 0 (sof is resync only, not mandatory).
- NNin retains its last frame after NNvalid drops; lanes are overwritten only as new pixels arrive.
- Back-to-back throughput: one pixel per cycle in FILL. Dead time per frame = 1 (PRESENT entry) + NN latency + 1.
- count is $clog2(NUM_INPUTS+1) bits wide and never exceeds NUM_INPUTS-1 while stored.

Decomposition:
- Shared package nn_pkg:
  - NN_NUM_INPUTS=784, NN_DATA_WIDTH=16, NN_PIX_WIDTH=8
  - typedef lane_t (logic signed [15:0])
  - enum asm_state_t {FILL, PRESENT}
- Sub-module nn_pix2fix: combinational shift+saturate; parameters PIX_WIDTH, DATA_WIDTH, PIX_SHIFT.
- Top holds the FSM, counter and the packed NNin register.

Test Plan:
- Reset: hold reset=0 two cycles with pix_valid=1 -> NNin=0, NNvalid=0, pix_ready=1, busy=0, frame_err=0, no lane written.
- Full frame: 784 pixels, pixel k = k[7:0], sof on first, valid every cycle -> NNvalid rises the cycle after the 784th accept. Lane 1 = 0x0020, lane 255 = 0x1FE0, lane 256 = 0x0000. pix_ready=0 until nn_done.
- Release: in PRESENT, pulse nn_done for 1 cycle after 5 idle cycles -> NNvalid low and pix_ready high the next cycle. NNin unchanged until the next accept. Earlier nn_done in FILL has no effect.
- Short frame: 100 pixels, then a pixel 0xFF with sof=1 -> frame_err pulses one cycle, lane 0 = 0x1FE0, count=1. Then 783 more pixels -> NNvalid after 784 total from the sof.
- Gapped stream: random pix_valid deassertion (about 50%) over a frame -> identical NNin to the gapless run, and NNvalid timing relative to the last accept unchanged.
- Reset mid-operation: reset=0 at pixel 400, and separately during PRESENT -> all outputs return to reset values the next cycle. The next frame starts at lane 0.
